// File: rtl/axis_fifo_sync_if.sv
// AXI4-Stream bundle used on both sides of axis_fifo_sync.
// The FIFO consumes a slave modport and produces on a master modport.
interface axis_fifo_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [STRB_WIDTH-1:0] tstrb;
  logic [STRB_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_fifo_sync.sv
// Single-clock AXI4-Stream FIFO with full sideband and live occupancy output.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward (whole-frame) release.
module axis_fifo_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  axis_fifo_sync_if.slave            s_axis,
  axis_fifo_sync_if.master           m_axis,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LW         = $clog2(DEPTH + 1);
  localparam int AW         = $clog2(DEPTH);
  localparam int EW         = DATA_WIDTH + 2 * STRB_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int LAST_BIT   = ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] count_reg, count_next;
  logic          s_ready_reg;
  logic          init_done_reg;
  logic          m_valid;
  logic          push, pop;
  logic [EW-1:0] wr_entry, rd_entry, out_entry;

  assign wr_entry = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                     s_axis.tid, s_axis.tdest, s_axis.tuser};
  assign rd_entry = mem[rd_ptr_reg];

  assign push = s_axis.tvalid && s_ready_reg;
  assign pop  = m_valid && m_axis.tready;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + LW'(1);
      2'b01:   count_next = count_reg - LW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Ready is a pure register: a pop while full only re-opens the input next cycle,
  // and init_done_reg holds it low for the first cycle after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      s_ready_reg   <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg   <= count_next;
      s_ready_reg <= init_done_reg && (count_next != LW'(DEPTH));
    end
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [LW-1:0] pkt_cnt_reg;
  logic          drain_reg;
  logic          push_last, pop_last;

  assign push_last = push && s_axis.tlast;
  assign pop_last  = pop && rd_entry[LAST_BIT];

  // drain lets an over-long frame flow once the FIFO is full with no complete packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_reg <= '0;
      drain_reg   <= 1'b0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   pkt_cnt_reg <= pkt_cnt_reg + LW'(1);
        2'b01:   pkt_cnt_reg <= pkt_cnt_reg - LW'(1);
        default: pkt_cnt_reg <= pkt_cnt_reg;
      endcase
      if (pop_last) begin
        drain_reg <= 1'b0;
      end else if ((count_reg == LW'(DEPTH)) && (pkt_cnt_reg == '0)) begin
        drain_reg <= 1'b1;
      end
    end
  end

  assign m_valid = (count_reg != '0) && ((pkt_cnt_reg != '0) || drain_reg);
`else
  assign m_valid = (count_reg != '0);
`endif

  // Payload is forced to zero whenever no beat is offered, which also covers reset.
  assign out_entry = m_valid ? rd_entry : '0;

  assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
          m_axis.tid, m_axis.tdest, m_axis.tuser} = out_entry;

  assign m_axis.tvalid = m_valid;
  assign s_axis.tready = s_ready_reg;
  assign level         = count_reg;
endmodule

// File: tb/tb_axis_fifo_sync.sv
// Directed self-checking bench for axis_fifo_sync (DEPTH=16, 32-bit data).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_axis_fifo_sync;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic        id;
    logic        dest;
    logic        user;
  } beat_t;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [4:0] level;

  int checks   = 0;
  int failures = 0;

  axis_fifo_sync_if #(.DATA_WIDTH(32)) s_if ();
  axis_fifo_sync_if #(.DATA_WIDTH(32)) m_if ();

  axis_fifo_sync #(.DATA_WIDTH(32), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DEPTH(DEPTH)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if),
    .m_axis  (m_if),
    .level   (level)
  );

  always #5 aclk = ~aclk;

  function automatic beat_t mk(input int i, input logic last);
    beat_t b;
    logic [31:0] iv;
    iv     = i;
    b.data = 32'hA500_0000 + iv;
    b.strb = ~iv[3:0];
    b.keep = iv[3:0];
    b.last = last;
    b.id   = iv[1];
    b.dest = iv[2];
    b.user = iv[0];
    return b;
  endfunction

  function automatic beat_t get_m();
    beat_t b;
    b.data = m_if.tdata;
    b.strb = m_if.tstrb;
    b.keep = m_if.tkeep;
    b.last = m_if.tlast;
    b.id   = m_if.tid;
    b.dest = m_if.tdest;
    b.user = m_if.tuser;
    return b;
  endfunction

  task automatic drive_s(input logic v, input beat_t b);
    s_if.tvalid = v;
    s_if.tdata  = b.data;
    s_if.tstrb  = b.strb;
    s_if.tkeep  = b.keep;
    s_if.tlast  = b.last;
    s_if.tid    = b.id;
    s_if.tdest  = b.dest;
    s_if.tuser  = b.user;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic release_reset();
    aresetn = 1'b1;
    step();
    checks++;
    if (s_if.tready !== 1'b0) begin
      failures++;
      $display("FAIL rst_first_cycle_ready got=%b want=0", s_if.tready);
    end
    step();
    checks++;
    if (s_if.tready !== 1'b1) begin
      failures++;
      $display("FAIL rst_second_edge_ready got=%b want=1", s_if.tready);
    end
  endtask

  task automatic test_reset();
    drive_s(1'b0, beat_t'('0));
    m_if.tready = 1'b0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({m_if.tvalid, s_if.tready, level} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl got tvalid=%b tready=%b level=%0d want 0/0/0", m_if.tvalid, s_if.tready, level);
    end
    checks++;
    if (get_m() !== beat_t'('0)) begin
      failures++;
      $display("FAIL reset_payload got=%h want=0", get_m());
    end
    release_reset();
    $display("test_reset: done");
  endtask

  task automatic test_fill_drain();
    m_if.tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (s_if.tready !== 1'b1) begin
        failures++;
        $display("FAIL fill_ready beat=%0d got=%b want=1", i, s_if.tready);
      end
      drive_s(1'b1, mk(i, 1'b1));
      step();
    end
    drive_s(1'b0, beat_t'('0));
    checks++;
    if (level !== 5'd16 || s_if.tready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got level=%0d tready=%b want 16/0", level, s_if.tready);
    end
    m_if.tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || get_m() !== mk(i, 1'b1)) begin
        failures++;
        $display("FAIL drain_beat idx=%0d got valid=%b beat=%h want 1/%h", i, m_if.tvalid, get_m(), mk(i, 1'b1));
      end
      step();
    end
    checks++;
    if (level !== 5'd0 || m_if.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty got level=%0d tvalid=%b want 0/0", level, m_if.tvalid);
    end
    m_if.tready = 1'b0;
    $display("test_fill_drain: done");
  endtask

  task automatic test_streaming();
    m_if.tready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      drive_s(1'b1, mk(100 + j, 1'b1));
      step();
      checks++;
      if (m_if.tvalid !== 1'b1 || get_m() !== mk(100 + j, 1'b1) || level !== 5'd1 || s_if.tready !== 1'b1) begin
        failures++;
        $display("FAIL stream idx=%0d got valid=%b data=%h level=%0d tready=%b want 1/%h/1/1",
                 j, m_if.tvalid, m_if.tdata, level, s_if.tready, mk(100 + j, 1'b1).data);
      end
    end
    drive_s(1'b0, beat_t'('0));
    step();
    checks++;
    if (level !== 5'd0 || m_if.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end got level=%0d tvalid=%b want 0/0", level, m_if.tvalid);
    end
    m_if.tready = 1'b0;
    $display("test_streaming: done");
  endtask

  task automatic test_full_boundary();
    m_if.tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_s(1'b1, mk(200 + i, 1'b1));
      step();
    end
    // Pop and offer a push on the same edge while full.
    drive_s(1'b1, mk(999, 1'b1));
    m_if.tready = 1'b1;
    checks++;
    if (s_if.tready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_before got=%b want=0", s_if.tready);
    end
    step();
    drive_s(1'b0, beat_t'('0));
    checks++;
    if (level !== 5'd15 || s_if.tready !== 1'b1) begin
      failures++;
      $display("FAIL full_boundary got level=%0d tready=%b want 15/1", level, s_if.tready);
    end
    for (int i = 1; i < DEPTH; i++) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || get_m() !== mk(200 + i, 1'b1)) begin
        failures++;
        $display("FAIL full_drain idx=%0d got valid=%b data=%h want 1/%h", i, m_if.tvalid, m_if.tdata, mk(200 + i, 1'b1).data);
      end
      step();
    end
    checks++;
    if (level !== 5'd0 || m_if.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL full_rejected_push got level=%0d tvalid=%b want 0/0", level, m_if.tvalid);
    end
    m_if.tready = 1'b0;
    $display("test_full_boundary: done");
  endtask

  task automatic test_back_pressure();
    beat_t       q[$];
    beat_t       cur, prev_out, exp_b;
    logic        stall_prev = 1'b0;
    logic        sv, mr;
    logic [15:0] lfsr = 16'hACE1;
    int          in_idx = 300;
    int          pops = 0;
    for (int c = 0; c < 300; c++) begin
      cur = get_m();
      if (stall_prev) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || cur !== prev_out) begin
          failures++;
          $display("FAIL bp_stable cycle=%0d got valid=%b beat=%h want 1/%h", c, m_if.tvalid, cur, prev_out);
        end
      end
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      sv = lfsr[0];
      mr = lfsr[5];
      m_if.tready = mr;
      drive_s(sv, mk(in_idx, in_idx[0]));
      if (m_if.tvalid && mr) begin
        exp_b = (q.size() > 0) ? q.pop_front() : beat_t'('0);
        checks++;
        if (cur !== exp_b) begin
          failures++;
          $display("FAIL bp_order pop=%0d got=%h want=%h", pops, cur, exp_b);
        end
        pops++;
      end
      if (sv && s_if.tready) begin
        q.push_back(mk(in_idx, in_idx[0]));
        in_idx++;
      end
      stall_prev = m_if.tvalid && !mr;
      prev_out   = cur;
      step();
    end
    drive_s(1'b0, beat_t'('0));
    m_if.tready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (!m_if.tvalid) break;
      exp_b = (q.size() > 0) ? q.pop_front() : beat_t'('0);
      checks++;
      if (get_m() !== exp_b) begin
        failures++;
        $display("FAIL bp_drain pop=%0d got=%h want=%h", pops, get_m(), exp_b);
      end
      pops++;
      step();
    end
    checks++;
    if (q.size() != 0 || level !== 5'd0) begin
      failures++;
      $display("FAIL bp_leftover got queue=%0d level=%0d want 0/0", q.size(), level);
    end
    m_if.tready = 1'b0;
    $display("test_back_pressure: done pops=%0d", pops);
  endtask

  task automatic test_reset_midstream();
    m_if.tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_s(1'b1, mk(400 + i, 1'b1));
      step();
    end
    drive_s(1'b0, beat_t'('0));
    checks++;
    if (level !== 5'd7) begin
      failures++;
      $display("FAIL mid_level_before got=%0d want=7", level);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || level !== 5'd0 || s_if.tready !== 1'b0 || get_m() !== beat_t'('0)) begin
      failures++;
      $display("FAIL mid_async_reset got valid=%b level=%0d tready=%b data=%h want 0/0/0/0",
               m_if.tvalid, level, s_if.tready, m_if.tdata);
    end
    repeat (2) @(posedge aclk);
    #1;
    release_reset();
    m_if.tready = 1'b1;
    checks++;
    if (m_if.tvalid !== 1'b0 || level !== 5'd0) begin
      failures++;
      $display("FAIL mid_stale got valid=%b level=%0d want 0/0", m_if.tvalid, level);
    end
    drive_s(1'b1, mk(500, 1'b1));
    step();
    drive_s(1'b0, beat_t'('0));
    checks++;
    if (m_if.tvalid !== 1'b1 || get_m() !== mk(500, 1'b1)) begin
      failures++;
      $display("FAIL mid_first_beat got valid=%b data=%h want 1/%h", m_if.tvalid, m_if.tdata, mk(500, 1'b1).data);
    end
    step();
    m_if.tready = 1'b0;
    $display("test_reset_midstream: done");
  endtask

`ifdef AXIS_FIFO_PACKET_MODE_EN
  task automatic test_packet_mode();
    int   in_idx = 0;
    int   out_idx = 0;
    logic drain_seen = 1'b0;
    m_if.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_s(1'b1, mk(600 + i, i == 4));
      step();
      checks++;
      if (m_if.tvalid !== (i == 4)) begin
        failures++;
        $display("FAIL pkt_hold beat=%0d got valid=%b want=%b", i, m_if.tvalid, i == 4);
      end
    end
    drive_s(1'b0, beat_t'('0));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m_if.tvalid !== 1'b1 || get_m() !== mk(600 + i, i == 4)) begin
        failures++;
        $display("FAIL pkt_out idx=%0d got valid=%b data=%h want 1/%h", i, m_if.tvalid, m_if.tdata, mk(600 + i, i == 4).data);
      end
      step();
    end
    for (int c = 0; c < 200; c++) begin
      if (in_idx >= 20 && out_idx >= 20) break;
      if (m_if.tvalid) begin
        if (!drain_seen) begin
          drain_seen = 1'b1;
          checks++;
          if (level !== 5'd16) begin
            failures++;
            $display("FAIL pkt_drain_level got=%0d want=16", level);
          end
        end
        checks++;
        if (get_m() !== mk(700 + out_idx, 1'b0)) begin
          failures++;
          $display("FAIL pkt_drain_beat idx=%0d got=%h want=%h", out_idx, m_if.tdata, mk(700 + out_idx, 1'b0).data);
        end
        out_idx++;
      end
      if (in_idx < 20) begin
        drive_s(1'b1, mk(700 + in_idx, 1'b0));
        if (s_if.tready) in_idx++;
      end else begin
        drive_s(1'b0, beat_t'('0));
      end
      step();
    end
    drive_s(1'b0, beat_t'('0));
    checks++;
    if (out_idx != 20) begin
      failures++;
      $display("FAIL pkt_drain_count got=%0d want=20", out_idx);
    end
    m_if.tready = 1'b0;
    $display("test_packet_mode: done");
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_boundary();
    test_back_pressure();
    test_reset_midstream();
`ifdef AXIS_FIFO_PACKET_MODE_EN
    test_packet_mode();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
